lfsr_roll_bcd: RTL
==================

// Module: lfsr_roll_bcd
// PURPOSE
//  Parametrised pseudo-random "dice roll" generator for the maths-game datapath.
//  - Free-running Fibonacci or Galois LFSR of configurable width, with runtime seed load.
//  - On a req/ready handshake, samples the LFSR and reduces it modulo MAX_VAL+1 sequentially.
//  - Converts the result to two BCD digits for the 7-seg drivers; result held until next roll.
// PARAMETERS
//  WIDTH    8      LFSR width, 3..16
//  TAPS     8'hB8  feedback mask, WIDTH bits; must give a maximal-length polynomial
//  GALOIS   0      0 = Fibonacci (shift left), 1 = Galois (shift right)
//  SEED     8'hA5  reset/fallback seed, WIDTH bits; must be non-zero
//  MAX_VAL  99     largest roll value, 1..99
// PORTS
//  clk        in   1      clock
//  rst        in   1      reset, asynchronous, active-high
//  en         in   1      LFSR advances on each clk while high; frozen while low
//  seed_load  in   1      load seed_in into LFSR this edge
//  seed_in    in   WIDTH  seed value (0 replaced by SEED)
//  req        in   1      roll request
//  ready      out  1      high in IDLE; roll accepted on edge with req&&ready
//  valid      out  1      one-cycle pulse: result outputs updated
//  sample     out  WIDTH  raw LFSR value captured at acceptance
//  result     out  7      sample mod (MAX_VAL+1)
//  bcd_tens   out  4      result/10
//  bcd_units  out  4      result%10
//  lfsr_state out  WIDTH  live LFSR register (drives LEDs)
// BEHAVIOUR
//  Reset values
//   - lfsr=SEED; FSM=IDLE; ready=1.
//   - valid, sample, result, bcd_tens, bcd_units all 0.
//  LFSR update (priority order, per edge)
//   1. seed_load: lfsr <= (seed_in==0) ? SEED : seed_in. Overrides en.
//   2. else if en, Fibonacci: lfsr <= {lfsr[WIDTH-2:0], ^(lfsr&TAPS)}.
//   3. else if en, Galois: lfsr <= lfsr[0] ? (lfsr>>1)^TAPS : lfsr>>1.
//   4. Lock-up guard: if lfsr==0 on any edge, load SEED instead.
//  FSM
//   - IDLE -> MOD on req&&ready.
//     - sample <= current lfsr (pre-update value, even with seed_load same edge).
//     - rem <= 0.
//   - MOD: WIDTH cycles, MSB first, restoring remainder.
//     - Per bit: r = {rem,bit}; rem <= (r >= MAX_VAL+1) ? r-(MAX_VAL+1) : r.
//     - rem 8 bits wide; no overflow since rem < 100.
//   - BCD: 7 cycles double-dabble on rem[6:0].
//     - Add 3 to any digit >= 5 before each shift.
//   - DONE: 1 cycle.
//     - result, bcd_tens, bcd_units updated; valid=1.
//     - Next state IDLE.
//  Timing and handshake
//   - Latency: valid high in cycle WIDTH+8 after accepting edge (16 for WIDTH=8).
//   - Outputs hold until next DONE.
//   - ready=0 in MOD/BCD/DONE; req while busy ignored (not queued).
//   - LFSR keeps running during a roll; en/seed_load never stall FSM.
//  Reset mid-roll
//   - Immediate return to IDLE; partial result discarded; all outputs to reset values.
// STRUCTURE
//  Shared package rng_pkg
//   - FSM state enum {IDLE,MOD,BCD,DONE}.
//   - Maximal-tap constants for WIDTH 3..16.
//   - Default SEED.
//  Sub-module rng_bin2bcd_seq
//   - 7-bit sequential double-dabble with start/done.
//  Top holds LFSR, modulo FSM and output registers.
// TESTING (WIDTH=8, TAPS=8'hB8, SEED=8'hA5, MAX_VAL=99)
//  1. Reset, en=0, req 1 cycle
//     -> sample=0xA5, result=65, tens=6, units=5, valid 16 cycles after accept.
//  2. seed_load seed_in=0x00, then en=0 roll
//     -> lfsr=0xA5, result=65.
//  3. en=0; seeds 0x63, 0x64, 0xFF each rolled
//     -> (9,9), (0,0), (5,5).
//  4. en=1 for 255 cycles from SEED, both GALOIS=0 and 1
//     -> lfsr never 0, returns to 0xA5 exactly at cycle 255, not before.
//  5. req held high continuously
//     -> exactly one valid per 17-cycle roll; ready low while busy.
//  6. rst asserted in MOD cycle 3
//     -> ready=1, valid=0, result=0, lfsr=0xA5 immediately.
//     -> next roll completes normally.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared types and constants for the dice-roll random number datapath.
// Pure declarations: no logic and no latency.
// No flow control here; consumers own their handshakes.
package rng_pkg;

    // Roll sequencer states
    typedef enum logic [1:0] {
        IDLE,
        MOD,
        BCD,
        DONE
    } roll_state_t;

    localparam logic [7:0] DEFAULT_SEED = 8'hA5;
    localparam logic [7:0] DEFAULT_TAPS = 8'hB8;

    // Maximal-length feedback masks for widths 3..16 (zero for unsupported widths)
    function automatic logic [15:0] max_taps(input int width);
        logic [15:0] t;
        case (width)
            3:       t = 16'h0006;
            4:       t = 16'h000C;
            5:       t = 16'h0014;
            6:       t = 16'h0030;
            7:       t = 16'h0060;
            8:       t = 16'h00B8;
            9:       t = 16'h0110;
            10:      t = 16'h0240;
            11:      t = 16'h0500;
            12:      t = 16'h0E08;
            13:      t = 16'h1C80;
            14:      t = 16'h3802;
            15:      t = 16'h6000;
            16:      t = 16'hD008;
            default: t = 16'h0000;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/rng_bin2bcd_seq.sv
// Sequential 7-bit binary to two-digit BCD converter (double-dabble).
// Latency: start edge loads, then 7 shift cycles; done is high during the last one.
// No backpressure: a new start restarts the conversion at once.
module rng_bin2bcd_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] bin,
    output logic       done,
    output logic [3:0] tens,
    output logic [3:0] units
);

    logic [6:0]  sr;
    logic [3:0]  tens_q;
    logic [3:0]  units_q;
    logic [2:0]  cnt;
    logic        busy;
    logic [3:0]  tens_adj;
    logic [3:0]  units_adj;
    logic [14:0] shv;

    // Add-3 correction on each digit, then one left shift of {tens, units, sr}.
    // tens/units expose the post-shift digits so the final value is visible
    // in the same cycle that done is high.
    always_comb begin
        tens_adj  = (tens_q  >= 4'd5) ? tens_q  + 4'd3 : tens_q;
        units_adj = (units_q >= 4'd5) ? units_q + 4'd3 : units_q;
        shv       = {tens_adj, units_adj, sr} << 1;
        tens      = shv[14:11];
        units     = shv[10:7];
        done      = busy && (cnt == 3'd1);
    end

    // Load on start, otherwise shift one bit per cycle while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr      <= '0;
            tens_q  <= '0;
            units_q <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
        end else if (start) begin
            sr      <= bin;
            tens_q  <= '0;
            units_q <= '0;
            cnt     <= 3'd7;
            busy    <= 1'b1;
        end else if (busy) begin
            sr      <= shv[6:0];
            tens_q  <= shv[14:11];
            units_q <= shv[10:7];
            cnt     <= cnt - 3'd1;
            if (cnt == 3'd1) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/lfsr_roll_bcd.sv
// Free-running LFSR dice roller: sample, reduce mod MAX_VAL+1, convert to BCD.
// Latency: valid pulses WIDTH+8 cycles after the accepting edge.
// ready is high only in IDLE; requests while busy are dropped, not queued.
module lfsr_roll_bcd
    import rng_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] TAPS    = DEFAULT_TAPS,
    parameter int               GALOIS  = 0,
    parameter logic [WIDTH-1:0] SEED    = DEFAULT_SEED,
    parameter int               MAX_VAL = 99
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] sample,
    output logic [6:0]       result,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_units,
    output logic [WIDTH-1:0] lfsr_state
);

    localparam logic [7:0] MOD_BASE = 8'(MAX_VAL + 1);
    localparam int         CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] lfsr_next;
    roll_state_t      state;
    roll_state_t      state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sh;
    logic [6:0]       rem;
    logic [7:0]       r;
    logic [6:0]       rem_step;
    logic             bcd_start;
    logic             bcd_done;
    logic [3:0]       dig_tens;
    logic [3:0]       dig_units;

    assign lfsr_state = lfsr;

    // LFSR next value: seed load wins, an all-zero register self-heals to SEED.
    always_comb begin
        lfsr_next = lfsr;
        if (seed_load) begin
            lfsr_next = (seed_in == '0) ? SEED : seed_in;
        end else if (lfsr == '0) begin
            lfsr_next = SEED;
        end else if (en) begin
            if (GALOIS != 0) begin
                lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
            end else begin
                lfsr_next = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
            end
        end
    end

    // LFSR register; runs independently of the roll sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED;
        end else begin
            lfsr <= lfsr_next;
        end
    end

    // Sequencer next state, restoring-remainder step and handshake outputs.
    always_comb begin
        state_next = state;
        r          = {rem, sh[WIDTH-1]};
        rem_step   = (r >= MOD_BASE) ? 7'(r - MOD_BASE) : r[6:0];
        bcd_start  = 1'b0;
        ready      = (state == IDLE);
        valid      = (state == DONE);
        case (state)
            IDLE: if (req) state_next = MOD;
            MOD: begin
                if (cnt == LAST_BIT) begin
                    state_next = BCD;
                    bcd_start  = 1'b1;
                end
            end
            BCD:  if (bcd_done) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sequencer state, working registers and held result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sh        <= '0;
            rem       <= '0;
            sample    <= '0;
            result    <= '0;
            bcd_tens  <= '0;
            bcd_units <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req) begin
                        sample <= lfsr;
                        sh     <= lfsr;
                        rem    <= '0;
                        cnt    <= '0;
                    end
                end
                MOD: begin
                    rem <= rem_step;
                    sh  <= {sh[WIDTH-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                end
                BCD: begin
                    if (bcd_done) begin
                        result    <= rem;
                        bcd_tens  <= dig_tens;
                        bcd_units <= dig_units;
                    end
                end
                default: ;
            endcase
        end
    end

    // The final remainder is handed over combinationally on the last MOD cycle.
    rng_bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (bcd_start),
        .bin   (rem_step),
        .done  (bcd_done),
        .tens  (dig_tens),
        .units (dig_units)
    );

endmodule
